// File: rtl/if_fetch_pkg.sv
// Shared definitions for the ysyx22040228 instruction-fetch stage:
// bus widths, PC-register stall encodings, FSM states and the fetch-buffer entry.
package if_fetch_pkg;

    localparam int PC_W   = 64;
    localparam int INST_W = 32;

    // PC register control: START lets it advance, STOP makes it hold.
    localparam logic START = 1'b0;
    localparam logic STOP  = 1'b1;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    localparam logic [1:0] FIFO_DEPTH = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              err;
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Two-entry registered {pc, inst, err} buffer between fetch and decode.
// A flush empties it on the same edge, overriding any push or pop.
module if_fifo
    import if_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [PC_W-1:0]   push_pc,
    input  logic [INST_W-1:0] push_inst,
    input  logic              push_err,
    input  logic              pop,
    output logic              valid,
    output logic [1:0]        count,
    output logic [PC_W-1:0]   head_pc,
    output logic [INST_W-1:0] head_inst,
    output logic              head_err
);

    fetch_entry_t entry_reg [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count_reg != 2'd0) && !flush;
    // Push into a full buffer is legal only when the head leaves the same cycle.
    assign do_push = push && !flush && ((count_reg != FIFO_DEPTH) || do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg[gi] <= '0;
                end else if (do_push && (int'(wr_ptr_reg) == gi)) begin
                    entry_reg[gi] <= '{pc: push_pc, inst: push_inst, err: push_err};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign valid     = (count_reg != 2'd0);
    assign count     = count_reg;
    assign head_pc   = entry_reg[rd_ptr_reg].pc;
    assign head_inst = entry_reg[rd_ptr_reg].inst;
    assign head_err  = entry_reg[rd_ptr_reg].err;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: one outstanding imem request, 2-entry buffer toward decode,
// stall/next-PC back to the PC register. Define YSYX22040228_IF_PREDECODE_EN for JAL prediction.
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              flush_i,
    output logic              pc_stall_o,
    output logic [PC_W-1:0]   static_pc_o,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [PC_W-1:0]   imem_req_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [INST_W-1:0] imem_rsp_data_i,
    input  logic              imem_rsp_err_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [PC_W-1:0]   id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_err_o
);

    fetch_state_e    state_reg;
    fetch_state_e    state_next;
    logic [PC_W-1:0] addr_reg;
    logic [PC_W-1:0] addr_next;
    logic            kill_reg;
    logic            kill_next;
    logic [PC_W-1:0] static_pc_reg;
    logic [PC_W-1:0] pred_pc;
    logic            stall;
    logic            req_valid;
    logic            rsp_take;
    logic            id_pop;
    logic            slot_left;
    logic [1:0]      fifo_count;

    assign rsp_take = (state_reg == WAIT) && imem_rsp_valid_i && !flush_i;
    assign id_pop   = id_valid_o && id_ready_i;

    // After this push, is there still room for another fetch?
    assign slot_left = (fifo_count == 2'd0) || ((fifo_count == 2'd1) && id_pop);

`ifdef YSYX22040228_IF_PREDECODE_EN
    always_comb begin
        pred_pc = addr_reg + 64'd4;
        if (!imem_rsp_err_i && (imem_rsp_data_i[6:0] == OPC_JAL)) begin
            pred_pc = addr_reg + {{43{imem_rsp_data_i[31]}}, imem_rsp_data_i[31],
                                  imem_rsp_data_i[19:12], imem_rsp_data_i[20],
                                  imem_rsp_data_i[30:21], 1'b0};
        end
    end
`else
    assign pred_pc = addr_reg + 64'd4;
`endif

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        kill_next  = kill_reg;
        stall      = STOP;
        req_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!flush_i && (fifo_count != FIFO_DEPTH)) begin
                    state_next = REQ;
                    addr_next  = pc_i;
                    kill_next  = 1'b0;
                end
            end
            REQ: begin
                req_valid = 1'b1;
                if (flush_i) begin
                    kill_next = 1'b1;
                end
                if (imem_req_ready_i) begin
                    state_next = (kill_reg || flush_i) ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid_i) begin
                    if (flush_i) begin
                        state_next = IDLE;
                    end else begin
                        stall = START;
                        if (slot_left) begin
                            // The PC register loads pred_pc on this same edge, so pc_i
                            // would only show it a cycle late; latch the value directly.
                            state_next = REQ;
                            addr_next  = pred_pc;
                            kill_next  = 1'b0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end else if (flush_i) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_rsp_valid_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            kill_reg      <= 1'b0;
            static_pc_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            kill_reg  <= kill_next;
            if (rsp_take) begin
                static_pc_reg <= pred_pc;
            end
        end
    end

    if_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_i),
        .push      (rsp_take),
        .push_pc   (addr_reg),
        .push_inst (imem_rsp_data_i),
        .push_err  (imem_rsp_err_i),
        .pop       (id_ready_i),
        .valid     (id_valid_o),
        .count     (fifo_count),
        .head_pc   (id_pc_o),
        .head_inst (id_inst_o),
        .head_err  (id_err_o)
    );

    // The prediction is live in the push cycle and held afterwards.
    assign static_pc_o      = rsp_take ? pred_pc : static_pc_reg;
    assign pc_stall_o       = stall;
    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = addr_reg;

endmodule
